// File: rtl/elastic_reg_pkg.sv
// Shared helpers for the elastic pipeline register: width derivation for
// pointers and occupancy count.
package elastic_reg_pkg;

   // Ceiling log2 usable in constant expressions; clog2(1) = 0.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

   // Occupancy ranges 0..depth inclusive, so it needs one more code than the pointers.
   function automatic int cnt_width(input int depth);
      return clog2(depth + 1);
   endfunction

   // A single-entry slice still needs a one-bit pointer to index storage.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/elastic_reg_entry.sv
// One WIDTH-bit storage word of the elastic register, reset to RESET_VAL and
// written only when its write enable is asserted.
module elastic_reg_entry #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RESET_VAL;
      end else if (wr_en) begin
         q <= wr_data;
      end
   end

endmodule

// File: rtl/elastic_reg.sv
// Elastic pipeline register: DEPTH-entry circular buffer with valid/ready on
// both sides, squash via flush, and a registered occupancy count.
module elastic_reg
   import elastic_reg_pkg::*;
#(
   parameter int unsigned      WIDTH     = 32,
   parameter int unsigned      DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
   localparam int unsigned     CNT_W     = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = ptr_width(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [PTR_W-1:0] wp;
   logic [PTR_W-1:0] rp;
   logic [CNT_W-1:0] cnt;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] entry_q [DEPTH];

   // Explicit wrap so non-power-of-two depths cycle through 0..DEPTH-1 only.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
   endfunction

   // Handshake decode: in_ready depends only on registered state and flush,
   // never on out_ready, so a full slice refuses a push even while popping.
   assign in_ready  = (cnt != CNT_FULL) & ~flush;
   assign out_valid = (cnt != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Storage: one entry per slot, written at the write pointer.
   for (genvar i = 0; i < int'(DEPTH); i++) begin : g_entry
      elastic_reg_entry #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_entry (
         .clk     (clk),
         .rst     (rst),
         .wr_en   (push & (wp == PTR_W'(i))),
         .wr_data (in_data),
         .q       (entry_q[i])
      );
   end

   assign out_data = entry_q[rp];

   // Pointer and occupancy state; a pop during flush is absorbed with no effect.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) begin
            wp <= ptr_next(wp);
         end
         if (pop) begin
            rp <= ptr_next(rp);
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign count = cnt;

endmodule

// File: tb/tb_elastic_reg.sv
// Directed bench for elastic_reg: reset, fill/drain, throughput, wrap-around,
// full-with-pop, flush and reset priority across DEPTH = 4, 2 and 3.
module tb_elastic_reg;

   localparam logic [31:0] RV = 32'hDEAD_BEEF;

   logic clk;
   logic rst;
   logic flush;

   logic        iv4, ir4, ov4, or4;
   logic [31:0] id4, od4;
   logic [2:0]  cnt4;

   logic        iv2, ir2, ov2, or2;
   logic [31:0] id2, od2;
   logic [1:0]  cnt2;

   logic        iv3, ir3, ov3, or3;
   logic [31:0] id3, od3;
   logic [1:0]  cnt3;

   int tests;
   int fails;

   elastic_reg #(.WIDTH(32), .DEPTH(4), .RESET_VAL(RV)) u_d4 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(iv4), .in_ready(ir4), .in_data(id4),
      .out_valid(ov4), .out_ready(or4), .out_data(od4), .count(cnt4)
   );

   elastic_reg #(.WIDTH(32), .DEPTH(2), .RESET_VAL(RV)) u_d2 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(iv2), .in_ready(ir2), .in_data(id2),
      .out_valid(ov2), .out_ready(or2), .out_data(od2), .count(cnt2)
   );

   elastic_reg #(.WIDTH(32), .DEPTH(3), .RESET_VAL(RV)) u_d3 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(iv3), .in_ready(ir3), .in_data(id3),
      .out_valid(ov3), .out_ready(or3), .out_data(od3), .count(cnt3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] q3[$];
      logic        p3, r3;

      tests = 0;
      fails = 0;
      rst = 1'b1; flush = 1'b0;
      iv4 = 1'b1; id4 = 32'h1234; or4 = 1'b0;
      iv2 = 1'b1; id2 = 32'h5678; or2 = 1'b0;
      iv3 = 1'b1; id3 = 32'h9ABC; or3 = 1'b0;

      // Reset held two cycles with in_valid high
      tick();
      tick();
      chk("rst_ov4", {31'd0, ov4}, 32'd0);
      chk("rst_ir4", {31'd0, ir4}, 32'd1);
      chk("rst_cnt4", {29'd0, cnt4}, 32'd0);
      chk("rst_od4", od4, RV);
      chk("rst_od2", od2, RV);
      chk("rst_cnt3", {30'd0, cnt3}, 32'd0);
      rst = 1'b0;
      iv4 = 1'b0; iv2 = 1'b0; iv3 = 1'b0;
      tick();
      chk("idle_cnt4", {29'd0, cnt4}, 32'd0);
      chk("idle_ov2", {31'd0, ov2}, 32'd0);

      // Fill DEPTH=4 with downstream stalled
      for (int k = 1; k <= 4; k++) begin
         iv4 = 1'b1;
         id4 = 32'h11 * k;
         tick();
         chk("fill_cnt4", {29'd0, cnt4}, 32'(k));
      end
      chk("full_ir4", {31'd0, ir4}, 32'd0);
      chk("full_ov4", {31'd0, ov4}, 32'd1);
      chk("full_od4", od4, 32'h11);
      id4 = 32'h55;
      tick();
      chk("fifth_cnt4", {29'd0, cnt4}, 32'd4);
      chk("fifth_od4", od4, 32'h11);
      iv4 = 1'b0;
      or4 = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk("drain_od4", od4, 32'h11 * k);
         chk("drain_ov4", {31'd0, ov4}, 32'd1);
         tick();
      end
      chk("drained_cnt4", {29'd0, cnt4}, 32'd0);
      chk("drained_ov4", {31'd0, ov4}, 32'd0);
      or4 = 1'b0;

      // Sustained one-per-cycle flow through DEPTH=2
      iv2 = 1'b1; or2 = 1'b1; id2 = 32'd0;
      for (int t = 1; t <= 100; t++) begin
         tick();
         chk("thru_od2", od2, 32'(t - 1));
         chk("thru_cnt2", {30'd0, cnt2}, 32'd1);
         chk("thru_ir2", {31'd0, ir2}, 32'd1);
         id2 = 32'(t);
      end
      iv2 = 1'b0;
      tick();
      chk("thru_end_cnt2", {30'd0, cnt2}, 32'd0);
      or2 = 1'b0;

      // DEPTH=3 random mix against a queue scoreboard across pointer wrap
      for (int c = 0; c < 40; c++) begin
         iv3 = 1'($urandom_range(0, 1));
         or3 = 1'($urandom_range(0, 1));
         id3 = $urandom;
         chk("wrap_cnt3", {30'd0, cnt3}, 32'(q3.size()));
         chk("wrap_ov3", {31'd0, ov3}, {31'd0, q3.size() != 0});
         chk("wrap_ir3", {31'd0, ir3}, {31'd0, q3.size() != 3});
         if (q3.size() != 0) chk("wrap_od3", od3, q3[0]);
         p3 = iv3 && (q3.size() < 3);
         r3 = or3 && (q3.size() > 0);
         tick();
         if (r3) void'(q3.pop_front());
         if (p3) q3.push_back(id3);
      end
      iv3 = 1'b0;
      or3 = 1'b1;
      while (q3.size() != 0) begin
         chk("wrap_drain_od3", od3, q3[0]);
         tick();
         void'(q3.pop_front());
      end
      chk("wrap_drained_cnt3", {30'd0, cnt3}, 32'd0);
      or3 = 1'b0;

      // Full with simultaneous pop: pop happens, push refused
      for (int k = 1; k <= 4; k++) begin
         iv4 = 1'b1;
         id4 = 32'hA0 + k;
         tick();
      end
      chk("fp_cnt4_pre", {29'd0, cnt4}, 32'd4);
      id4 = 32'hA5;
      or4 = 1'b1;
      tick();
      chk("fp_cnt4", {29'd0, cnt4}, 32'd3);
      chk("fp_od4", od4, 32'hA2);
      iv4 = 1'b0;
      or4 = 1'b0;

      // Flush with in_valid high discards everything
      flush = 1'b1;
      iv4 = 1'b1;
      id4 = 32'hBB;
      #1;
      chk("fl_ir4", {31'd0, ir4}, 32'd0);
      tick();
      flush = 1'b0;
      iv4 = 1'b0;
      #1;
      chk("fl_cnt4", {29'd0, cnt4}, 32'd0);
      chk("fl_ov4", {31'd0, ov4}, 32'd0);
      chk("fl_ir4_after", {31'd0, ir4}, 32'd1);
      iv4 = 1'b1;
      id4 = 32'hCC;
      tick();
      iv4 = 1'b0;
      chk("fl_post_od4", od4, 32'hCC);
      chk("fl_post_cnt4", {29'd0, cnt4}, 32'd1);

      // Reset and flush together restore reset values and entry contents
      for (int k = 1; k <= 3; k++) begin
         iv4 = 1'b1;
         id4 = 32'hD0 + k;
         tick();
      end
      chk("rf_cnt4_pre", {29'd0, cnt4}, 32'd4);
      rst = 1'b1;
      flush = 1'b1;
      id4 = 32'hEE;
      tick();
      rst = 1'b0;
      flush = 1'b0;
      iv4 = 1'b0;
      #1;
      chk("rf_cnt4", {29'd0, cnt4}, 32'd0);
      chk("rf_ov4", {31'd0, ov4}, 32'd0);
      chk("rf_ir4", {31'd0, ir4}, 32'd1);
      chk("rf_od4_e0", od4, RV);
      iv4 = 1'b1;
      id4 = 32'h77;
      tick();
      iv4 = 1'b0;
      or4 = 1'b1;
      chk("rf_push_od4", od4, 32'h77);
      tick();
      or4 = 1'b0;
      chk("rf_od4_e1", od4, RV);
      chk("rf_end_ov4", {31'd0, ov4}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/elastic_reg.md
# elastic_reg

Parametrised elastic pipeline register: a DEPTH-entry, WIDTH-bit storage slice with valid/ready handshakes on both sides, a pipeline flush and an occupancy count. It generalises the plain write-enabled register into a stall-tolerant stage buffer. It sits between core pipeline stages (e.g. decode→rename, rename→dispatch) where the downstream stage can back-pressure and mispredict recovery must squash in-flight entries.

## Interface
- WIDTH, 32, payload bits per entry
- DEPTH, 2, number of entries; legal values 1..16, power of two not required
- RESET_VAL, {WIDTH{1'b0}}, value loaded into every entry on reset
- CNT_W, $clog2(DEPTH+1), width of count (derived, not overridden)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries (squash)
- in_valid  in  1  upstream offers in_data
- in_ready  out  1  slice accepts this cycle
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  head entry is valid
- out_ready  in  1  downstream accepts head this cycle
- out_data  out  WIDTH  head entry payload
- count  out  CNT_W  number of valid entries (0..DEPTH)

## Operation
- Circular buffer: write pointer wp, read pointer rp (0..DEPTH-1, wrap DEPTH-1→0 explicitly, no power-of-two masking), occupancy cnt.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (cnt != DEPTH) & ~flush. No combinational path from out_ready to in_ready: a full slice refuses a push even if the head pops that cycle.
- out_valid = (cnt != 0); out_data = entry[rp], driven straight from storage, no combinational path from in_data.
- push: entry[wp] ← in_data, wp advances. pop: rp advances. cnt ← cnt + push − pop.
- Push and pop together (0 < cnt < DEPTH): both occur, cnt unchanged.
- flush (and not rst): wp ← 0, rp ← 0, cnt ← 0 next edge; push blocked by in_ready=0; a pop handshake in the flush cycle is still counted as consumed by downstream but has no effect on state. Entry contents are not cleared by flush.
- rst overrides flush and all handshakes: wp=rp=cnt=0, every entry ← RESET_VAL.
- Protocol rules: once out_valid=1 it stays 1 and out_data stays stable until pop, flush or rst. Upstream may drop in_valid without a handshake; slice imposes nothing on it.

## Timing
- Latency: data pushed at edge N is visible on out_data with out_valid=1 after edge N (cycle N+1) when the slice was empty; no same-cycle pass-through.
- Throughput: one push and one pop per cycle sustained for DEPTH ≥ 2. DEPTH=1 gives half throughput under continuous flow, by design.
- Reset values (cycle after rst): out_valid=0, in_ready=1, count=0, out_data=RESET_VAL.
- Flush: cycle after flush edge, out_valid=0, count=0, in_ready=1 (if flush deasserted).
- count is a register output, updated at the same edge as pointers.

## Structure
- One sub-module: elastic_reg_entry (WIDTH-bit storage, sync active-high reset to RESET_VAL, write enable); instantiated DEPTH times via generate, we = push & (wp == i).
- Pointer/count logic and read mux in the top level; read mux is a plain index of the entry array.
- No package typedefs required; if a shared core package exists, CNT_W derivation uses its clog2 helper. Payload structs are packed by the caller into WIDTH.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 → out_valid=0, in_ready=1, count=0, out_data=RESET_VAL (use RESET_VAL=32'hDEAD_BEEF).
- Fill/drain, DEPTH=4: out_ready=0, push 0x11,0x22,0x33,0x44 → count=4, in_ready=0, fifth push ignored; then out_ready=1 → outputs 0x11..0x44 in order, count back to 0.
- Full throughput, DEPTH=2: continuous in_valid/out_ready for 100 cycles with incrementing data → one output per cycle after the first, count steady at 1, no loss or reorder.
- Wrap-around, DEPTH=3 (non power of two): 10 push/pop mixes with random out_ready → order preserved across pointer wrap; scoreboard matches.
- Full with simultaneous pop: cnt=DEPTH, in_valid=1, out_ready=1 → pop occurs, push refused, count=DEPTH−1.
- Flush and rst priority: count=3, assert flush with in_valid=1 → count=0, out_valid=0 next cycle, pushed data never appears; assert rst and flush together → reset values and entries = RESET_VAL.
